// File: rtl/call_ret_ctrl.sv
// Call/return controller: pushes return addresses on a call, pops them on a return
// and redirects the PC; keeps its own occupancy count of the external stack.
module call_ret_ctrl #(
   parameter int WIDTH_DATA = 32,
   parameter int DEPTH      = 10,
   parameter int PC_INC     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call,
   input  logic                  ret,
   input  logic [WIDTH_DATA-1:0] pc,
   input  logic [WIDTH_DATA-1:0] call_target,
   input  logic [WIDTH_DATA-1:0] stk_data_out,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [WIDTH_DATA-1:0] stk_data_in,
   output logic                  pc_load,
   output logic [WIDTH_DATA-1:0] pc_next,
   output logic                  busy,
   output logic                  overflow_err,
   output logic                  underflow_err,
   output logic                  illegal_err
);

   localparam int                  CW        = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]       COUNT_MAX = CW'(DEPTH);
   localparam logic [WIDTH_DATA-1:0] INC     = WIDTH_DATA'(PC_INC);

   typedef enum logic [1:0] {
      IDLE,
      POP,
      WAIT
   } state_e;

   state_e        state_q;
   logic [CW-1:0] count_q;

   // Strobes default low every cycle so each accepted request yields a single pulse;
   // the popped word arrives during WAIT and is loaded straight into pc_next.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         stk_push      <= 1'b0;
         stk_pop       <= 1'b0;
         stk_data_in   <= '0;
         pc_load       <= 1'b0;
         pc_next       <= '0;
         busy          <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         illegal_err   <= 1'b0;
      end else begin
         stk_push <= 1'b0;
         stk_pop  <= 1'b0;
         pc_load  <= 1'b0;
         case (state_q)
            IDLE: begin
               busy <= 1'b0;
               if (call && ret) begin
                  illegal_err <= 1'b1;
               end else if (call) begin
                  if (count_q == COUNT_MAX) begin
                     overflow_err <= 1'b1;
                  end else begin
                     stk_push    <= 1'b1;
                     stk_data_in <= pc + INC;
                     pc_load     <= 1'b1;
                     pc_next     <= call_target;
                     count_q     <= count_q + 1'b1;
                  end
               end else if (ret) begin
                  if (count_q == '0) begin
                     underflow_err <= 1'b1;
                  end else begin
                     stk_pop <= 1'b1;
                     busy    <= 1'b1;
                     count_q <= count_q - 1'b1;
                     state_q <= POP;
                  end
               end
            end
            POP: begin
               busy    <= 1'b1;
               state_q <= WAIT;
            end
            WAIT: begin
               busy    <= 1'b0;
               pc_load <= 1'b1;
               pc_next <= stk_data_out;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
